// File: rtl/generation_scheduler_pkg.sv
// Shared types and defaults for the generation scheduler.
// Holds the FSM state type and parameter defaults.
`timescale 1ns/1ps
package generation_scheduler_pkg;

  localparam int PERIOD_W_DEF = 26;
  localparam int GEN_W_DEF    = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_VBLANK,
    S_GRAB,
    S_WRITE
  } state_t;

endpackage

// File: rtl/period_ticker.sv
// Free-running period tick generator for the generation scheduler.
// Counts while run=1 and pulses tick once per max(period,1) clocks.
`timescale 1ns/1ps
module period_ticker
  import generation_scheduler_pkg::*;
#(
  parameter int PERIOD_W = PERIOD_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] r_cnt;
  logic [PERIOD_W-1:0] w_last;

  assign w_last = (period == '0) ? '0 : period - PERIOD_W'(1);

  // >= so a shortened period takes effect without waiting for wrap
  assign tick = run && (r_cnt >= w_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!run || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/generation_scheduler.sv
// Schedules life generations: waits for vblank, grabs the framebuffer,
// starts the iteration writer and counts completed generations.
`timescale 1ns/1ps
module generation_scheduler
  import generation_scheduler_pkg::*;
#(
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int GEN_W    = GEN_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                step,
  input  logic [PERIOD_W-1:0] period,
  input  logic                vblank,
  input  logic                finished,
  output logic                grab_data,
  output logic                framebuffer_mutex,
  output logic                busy,
  output logic [GEN_W-1:0]    generation,
  output logic                overrun
);

  state_t           r_state;
  logic             r_pending;
  logic             r_grab;
  logic             r_mutex;
  logic             r_busy;
  logic [GEN_W-1:0] r_gen;
  logic             r_overrun;

  logic w_tick;
  logic w_req;
  logic w_clear;

  period_ticker #(
    .PERIOD_W(PERIOD_W)
  ) u_ticker (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .period(period),
    .tick  (w_tick)
  );

  assign w_req   = w_tick | (step & ~run);
  assign w_clear = (r_state == S_WAIT_VBLANK) && vblank;

  // A request landing on the clearing cycle is kept, not counted as overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_clear) begin
      r_pending <= w_req;
    end else if (w_req) begin
      r_pending <= 1'b1;
      if (r_pending) begin
        r_overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_grab  <= 1'b0;
      r_mutex <= 1'b0;
      r_busy  <= 1'b0;
      r_gen   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (r_pending) begin
            r_state <= S_WAIT_VBLANK;
            r_busy  <= 1'b1;
          end
        end
        S_WAIT_VBLANK: begin
          if (vblank) begin
            r_state <= S_GRAB;
            r_grab  <= 1'b1;
            r_mutex <= 1'b1;
          end
        end
        S_GRAB: begin
          r_state <= S_WRITE;
          r_grab  <= 1'b0;
        end
        S_WRITE: begin
          if (finished) begin
            r_state <= S_IDLE;
            r_mutex <= 1'b0;
            r_busy  <= 1'b0;
            r_gen   <= r_gen + GEN_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign grab_data         = r_grab;
  assign framebuffer_mutex = r_mutex;
  assign busy              = r_busy;
  assign generation        = r_gen;
  assign overrun           = r_overrun;

endmodule

// File: tb/tb_generation_scheduler.sv
// Self-checking bench for generation_scheduler.
// Behavioural model stepped alongside two DUTs (GEN_W 16 and 4).
`timescale 1ns/1ps
module tb_generation_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic [25:0] period = '0;
  logic        vblank = 1'b0;
  logic        finished = 1'b0;

  logic        grab_data, framebuffer_mutex, busy, overrun;
  logic [15:0] generation;
  logic        g4_grab, g4_mutex, g4_busy, g4_ovr;
  logic [3:0]  g4_gen;

  generation_scheduler dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step),
    .period(period), .vblank(vblank), .finished(finished),
    .grab_data(grab_data), .framebuffer_mutex(framebuffer_mutex),
    .busy(busy), .generation(generation), .overrun(overrun)
  );

  generation_scheduler #(.GEN_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step),
    .period(period), .vblank(vblank), .finished(finished),
    .grab_data(g4_grab), .framebuffer_mutex(g4_mutex),
    .busy(g4_busy), .generation(g4_gen), .overrun(g4_ovr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // model: phase 0 idle, 1 waiting vblank, 2 grab, 3 writing
  int m_cnt, m_ph, m_gen;
  bit m_pend, m_ovr;

  logic [27:0] obs;
  assign obs = {grab_data, framebuffer_mutex, busy, overrun,
                g4_grab, g4_mutex, g4_busy, g4_ovr,
                generation, g4_gen};

  function automatic logic [27:0] exp_vec();
    logic g, m, b;
    g = (m_ph == 2);
    m = (m_ph == 2) || (m_ph == 3);
    b = (m_ph != 0);
    return {g, m, b, m_ovr, g, m, b, m_ovr, 16'(m_gen), 4'(m_gen)};
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_ph = 0; m_gen = 0; m_pend = 0; m_ovr = 0;
  endtask

  task automatic model_step();
    int p;
    bit tk, old_pend, clr;
    p = (period == 0) ? 1 : int'(period);
    tk = 0;
    if (!run) m_cnt = 0;
    else if (m_cnt + 1 >= p) begin tk = 1; m_cnt = 0; end
    else m_cnt++;
    if (step && !run) tk = 1;
    old_pend = m_pend;
    clr = (m_ph == 1) && vblank;
    case (m_ph)
      0: if (old_pend) m_ph = 1;
      1: if (vblank) m_ph = 2;
      2: m_ph = 3;
      default: if (finished) begin m_ph = 0; m_gen++; end
    endcase
    if (clr) m_pend = tk;
    else if (tk) begin
      if (old_pend) m_ovr = 1;
      m_pend = 1;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic apply_reset();
    run = 0; step = 0; vblank = 0; finished = 0; period = '0;
    rst_n = 0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    run = 1; step = 1; vblank = 1; finished = 1; period = 26'd1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (obs !== 28'h0) begin
        n_err++;
        $display("FAIL reset: got %h want 0", obs);
      end
    end
    apply_reset();
  endtask

  task automatic test_free_run();
    int last, ngrab;
    apply_reset();
    period = 26'd4; run = 1; vblank = 1; finished = 1;
    last = -1; ngrab = 0;
    for (int c = 0; c < 40; c++) begin
      cyc();
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL free_run c%0d: got %h want %h", c, obs, exp_vec());
      end
      if (grab_data) begin
        if (last >= 0) begin
          n_vec++;
          if (c - last != 4) begin
            n_err++;
            $display("FAIL free_run spacing: got %0d want 4", c - last);
          end
        end
        last = c;
        ngrab++;
      end
    end
    n_vec++;
    if (ngrab != 9 || overrun !== 1'b0) begin
      n_err++;
      $display("FAIL free_run count: got %0d ovr %b want 9 ovr 0", ngrab, overrun);
    end
  endtask

  task automatic test_step();
    apply_reset();
    run = 0; vblank = 0; finished = 0;
    step = 1;
    cyc();
    step = 0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      n_vec++;
      if (grab_data !== 1'b0 || framebuffer_mutex !== 1'b0 || obs !== exp_vec()) begin
        n_err++;
        $display("FAIL step_wait c%0d: got %h want %h", c, obs, exp_vec());
      end
    end
    vblank = 1;
    cyc();
    n_vec++;
    if ({grab_data, framebuffer_mutex} !== 2'b11 || obs !== exp_vec()) begin
      n_err++;
      $display("FAIL step_grab: got %b%b want 11", grab_data, framebuffer_mutex);
    end
    cyc();
    n_vec++;
    if ({grab_data, framebuffer_mutex} !== 2'b01) begin
      n_err++;
      $display("FAIL step_write: got %b%b want 01", grab_data, framebuffer_mutex);
    end
    finished = 1;
    for (int c = 0; c < 6; c++) begin
      cyc();
      n_vec++;
      if (generation !== 16'd1 || framebuffer_mutex !== 1'b0 || obs !== exp_vec()) begin
        n_err++;
        $display("FAIL step_done c%0d: got gen %0d want 1", c, generation);
      end
    end
  endtask

  task automatic test_overrun();
    apply_reset();
    period = 26'd2; run = 1; vblank = 1; finished = 0;
    for (int c = 0; c < 20; c++) begin
      cyc();
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL overrun_hold c%0d: got %h want %h", c, obs, exp_vec());
      end
    end
    n_vec++;
    if (overrun !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_flag: got %b want 1", overrun);
    end
    run = 0; finished = 1;
    for (int c = 0; c < 10; c++) begin
      cyc();
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL overrun_drain c%0d: got %h want %h", c, obs, exp_vec());
      end
    end
    n_vec++;
    if (generation !== 16'd2 || busy !== 1'b0 || overrun !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_total: got gen %0d busy %b want 2 0", generation, busy);
    end
  endtask

  task automatic test_period_zero();
    apply_reset();
    period = '0; run = 1; vblank = 1; finished = 1;
    for (int c = 0; c < 30; c++) begin
      cyc();
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL period0 c%0d: got %h want %h", c, obs, exp_vec());
      end
    end
    n_vec++;
    if (generation !== 16'd7) begin
      n_err++;
      $display("FAIL period0_gen: got %0d want 7", generation);
    end
  endtask

  task automatic one_gen();
    step = 1;
    cyc();
    step = 0;
    repeat (4) cyc();
  endtask

  task automatic test_reset_mid_write();
    apply_reset();
    run = 0; vblank = 1; finished = 1;
    for (int g = 0; g < 5; g++) one_gen();
    n_vec++;
    if (generation !== 16'd5 || obs !== exp_vec()) begin
      n_err++;
      $display("FAIL midrst_pre: got gen %0d want 5", generation);
    end
    finished = 0;
    step = 1;
    cyc();
    step = 0;
    repeat (3) cyc();
    n_vec++;
    if (framebuffer_mutex !== 1'b1 || obs !== exp_vec()) begin
      n_err++;
      $display("FAIL midrst_write: got %h want %h", obs, exp_vec());
    end
    #3;
    rst_n = 0;
    model_reset();
    #1;
    n_vec++;
    if (obs !== 28'h0) begin
      n_err++;
      $display("FAIL midrst_async: got %h want 0", obs);
    end
    @(posedge clk);
    #1;
    rst_n = 1;
    finished = 1;
    for (int c = 0; c < 5; c++) begin
      cyc();
      n_vec++;
      if (generation !== 16'd0 || obs !== exp_vec()) begin
        n_err++;
        $display("FAIL midrst_after c%0d: got gen %0d want 0", c, generation);
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] want;
    apply_reset();
    run = 0; vblank = 1; finished = 1;
    want = 4'd0;
    for (int g = 1; g <= 17; g++) begin
      one_gen();
      want = want + 4'd1;
      n_vec++;
      if (g4_gen !== want || obs !== exp_vec()) begin
        n_err++;
        $display("FAIL wrap g%0d: got %0d want %0d", g, g4_gen, want);
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    period = 26'd3;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 63) == 0) period = 26'($urandom_range(0, 5));
      if ($urandom_range(0, 15) == 0) run = ~run;
      step = ($urandom_range(0, 7) == 0);
      vblank = ($urandom_range(0, 3) != 0);
      finished = ($urandom_range(0, 2) == 0);
      cyc();
      n_vec++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL random c%0d: got %h want %h", c, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_step();
    test_overrun();
    test_period_zero();
    test_reset_mid_write();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
